// File: rtl/task_sequencer.sv
// Walks the enabled task mask, launches each engine, times it and posts the latency word to memory.
// Optional watchdog: define TASK_TIMEOUT_EN to add TIMEOUT_CYCLES and the sticky task_timeout output.
module task_sequencer #(
  parameter int          NUM_TASKS     = 14,
  parameter logic [31:0] OUT_BASE_ADDR = 32'hA000_2000
`ifdef TASK_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] enabled_tasks,
  input  logic [31:0] num_bytes_in_to_task,
  input  logic        start_tests,
  output logic [31:0] current_task_number,
  output logic        task_start,
  output logic [31:0] task_num_bytes_in,
  input  logic        task_done,
  input  logic [31:0] task_num_bytes_out,
  output logic [31:0] num_bytes_out_from_task,
  output logic        num_bytes_out_from_task_valid,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic        tasks_done
`ifdef TASK_TIMEOUT_EN
  , output logic      task_timeout
`endif
);

  typedef enum logic [2:0] {IDLE, SCAN, START, RUN, LAT_WR} state_t;

  function automatic logic [31:0] valid_mask_f();
    logic [31:0] m;
    m = '0;
    for (int i = 1; i <= NUM_TASKS && i < 32; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] VALID_MASK = valid_mask_f();

  state_t      state, next_state;
  logic [31:0] mask_q;
  logic [31:0] lat_cnt;
  logic        found;
  logic [31:0] lowest;

  // Lowest pending task wins, so tasks run in ascending order.
  always_comb begin
    found  = 1'b0;
    lowest = '0;
    for (int i = NUM_TASKS; i >= 1; i--) begin
      if (mask_q[i]) begin
        found  = 1'b1;
        lowest = 32'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start_tests) next_state = SCAN;
      SCAN:   next_state = found ? START : IDLE;
      START:  next_state = RUN;
      RUN: begin
        if (task_done) next_state = LAT_WR;
`ifdef TASK_TIMEOUT_EN
        else if (lat_cnt == TIMEOUT_CYCLES) next_state = LAT_WR;
`endif
      end
      LAT_WR: if (wr_ack) next_state = SCAN;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    task_start = (state == START);
    wr_req     = (state == LAT_WR);
  end

  // Datapath registers; wr_addr/wr_data only change in RUN, so they hold while wr_req is up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q                        <= '0;
      lat_cnt                       <= '0;
      current_task_number           <= '0;
      task_num_bytes_in             <= '0;
      num_bytes_out_from_task       <= '0;
      num_bytes_out_from_task_valid <= 1'b0;
      wr_addr                       <= '0;
      wr_data                       <= '0;
      tasks_done                    <= 1'b0;
`ifdef TASK_TIMEOUT_EN
      task_timeout                  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_tests) begin
            mask_q            <= enabled_tasks & VALID_MASK;
            task_num_bytes_in <= num_bytes_in_to_task;
            tasks_done        <= 1'b0;
`ifdef TASK_TIMEOUT_EN
            task_timeout      <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (found) begin
            current_task_number <= lowest;
          end else begin
            current_task_number <= '0;
            tasks_done          <= 1'b1;
          end
        end
        START: begin
          num_bytes_out_from_task_valid <= 1'b0;
          lat_cnt                       <= 32'd1;
        end
        RUN: begin
          if (task_done) begin
            num_bytes_out_from_task       <= task_num_bytes_out;
            num_bytes_out_from_task_valid <= 1'b1;
            wr_addr <= OUT_BASE_ADDR + ((task_num_bytes_out + 32'd3) & ~32'd3);
            wr_data <= lat_cnt;
          end
`ifdef TASK_TIMEOUT_EN
          else if (lat_cnt == TIMEOUT_CYCLES) begin
            task_timeout                  <= 1'b1;
            num_bytes_out_from_task       <= '0;
            num_bytes_out_from_task_valid <= 1'b1;
            wr_addr                       <= OUT_BASE_ADDR;
            wr_data                       <= 32'hFFFF_FFFF;
          end
`endif
          else if (lat_cnt != 32'hFFFF_FFFF) begin
            lat_cnt <= lat_cnt + 32'd1;
          end
        end
        LAT_WR: begin
          if (wr_ack) mask_q <= mask_q & ~(32'd1 << current_task_number[4:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_task_sequencer.sv
// Directed bench for task_sequencer: an engine model answers each launch and a
// scoreboard queue holds the latency write expected for every completed task.
module tb_task_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] enabled_tasks;
  logic [31:0] num_bytes_in_to_task;
  logic        start_tests;
  logic [31:0] current_task_number;
  logic        task_start;
  logic [31:0] task_num_bytes_in;
  logic        task_done;
  logic [31:0] task_num_bytes_out;
  logic [31:0] num_bytes_out_from_task;
  logic        num_bytes_out_from_task_valid;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        tasks_done;
`ifdef TASK_TIMEOUT_EN
  logic        task_timeout;
`endif

  localparam logic [31:0] BASE = 32'hA000_2000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] bytes;
  } wr_exp_t;

  wr_exp_t     sb[$];
  int          checks = 0;
  int          errors = 0;
  int          starts_seen = 0;
  logic [31:0] cur_bytes_in = '0;

  always #5 clk = ~clk;

`ifdef TASK_TIMEOUT_EN
  task_sequencer #(.TIMEOUT_CYCLES(32'd100)) dut (
`else
  task_sequencer dut (
`endif
    .clk(clk),
    .reset(reset),
    .enabled_tasks(enabled_tasks),
    .num_bytes_in_to_task(num_bytes_in_to_task),
    .start_tests(start_tests),
    .current_task_number(current_task_number),
    .task_start(task_start),
    .task_num_bytes_in(task_num_bytes_in),
    .task_done(task_done),
    .task_num_bytes_out(task_num_bytes_out),
    .num_bytes_out_from_task(num_bytes_out_from_task),
    .num_bytes_out_from_task_valid(num_bytes_out_from_task_valid),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .tasks_done(tasks_done)
`ifdef TASK_TIMEOUT_EN
    , .task_timeout(task_timeout)
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=no_event expected=event_within_bound", tag);
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] bytes);
    logic [31:0] pad;
    pad = (32'd4 - (bytes % 32'd4)) % 32'd4;
    return BASE + bytes + pad;
  endfunction

  task automatic apply_stimulus(input logic [31:0] mask, input logic [31:0] bytes_in);
    enabled_tasks        = mask;
    num_bytes_in_to_task = bytes_in;
    cur_bytes_in         = bytes_in;
    start_tests          = 1'b1;
    tick();
    start_tests          = 1'b0;
  endtask

  task automatic wait_task_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (task_start) begin
        ok = 1'b1;
        starts_seen++;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (tasks_done) return;
      if (task_start) starts_seen++;
      tick();
    end
    bound_fail(tag);
  endtask

  task automatic watch_idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (task_start) starts_seen++;
      tick();
    end
  endtask

  task automatic check_output(input int ack_delay);
    wr_exp_t e;
    e = '0;
    check("wr_req_high", {31'd0, wr_req}, 32'd1);
    if (sb.size() == 0) begin
      bound_fail("scoreboard_entry");
      return;
    end
    e = sb.pop_front();
    check("wr_addr", wr_addr, e.addr);
    check("wr_data", wr_data, e.data);
    check("bytes_out", num_bytes_out_from_task, e.bytes);
    check("bytes_out_valid", {31'd0, num_bytes_out_from_task_valid}, 32'd1);
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check("wr_req_hold", {31'd0, wr_req}, 32'd1);
      check("wr_addr_hold", wr_addr, e.addr);
      check("wr_data_hold", wr_data, e.data);
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("wr_req_drop", {31'd0, wr_req}, 32'd0);
  endtask

  task automatic run_task(input logic [31:0] exp_task, input int latency,
                          input logic [31:0] bytes_out, input int ack_delay, input bit poke_start);
    bit ok;
    wait_task_start(ok);
    if (!ok) begin
      bound_fail("task_start_seen");
      return;
    end
    check("current_task", current_task_number, exp_task);
    check("task_num_bytes_in", task_num_bytes_in, cur_bytes_in);
    tick();
    check("valid_cleared", {31'd0, num_bytes_out_from_task_valid}, 32'd0);
    for (int i = 1; i < latency; i++) begin
      start_tests          = poke_start && (i == 2);
      enabled_tasks        = poke_start ? 32'h0000_FFFF : enabled_tasks;
      num_bytes_in_to_task = poke_start ? 32'h1234_5678 : num_bytes_in_to_task;
      tick();
      check("no_restart_in_run", {31'd0, task_start}, 32'd0);
    end
    start_tests = 1'b0;
    sb.push_back('{addr: exp_addr(bytes_out), data: 32'(latency), bytes: bytes_out});
    task_done          = 1'b1;
    task_num_bytes_out = bytes_out;
    tick();
    task_done          = 1'b0;
    task_num_bytes_out = 32'hDEAD_BEEF;
    check_output(ack_delay);
  endtask

  task automatic check_reset_outputs();
    check("rst_current_task", current_task_number, 32'd0);
    check("rst_task_start", {31'd0, task_start}, 32'd0);
    check("rst_bytes_in", task_num_bytes_in, 32'd0);
    check("rst_bytes_out", num_bytes_out_from_task, 32'd0);
    check("rst_valid", {31'd0, num_bytes_out_from_task_valid}, 32'd0);
    check("rst_wr_req", {31'd0, wr_req}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_tasks_done", {31'd0, tasks_done}, 32'd0);
  endtask

  task automatic case_one();
    apply_stimulus(32'h0000_0002, 32'd64);
    run_task(32'd1, 20, 32'd7, 0, 1'b0);
    wait_done("case1_tasks_done");
    check("case1_tasks_done", {31'd0, tasks_done}, 32'd1);
    check("case1_current_zero", current_task_number, 32'd0);
    check("case1_bytes_kept", num_bytes_out_from_task, 32'd7);
    check("case1_valid_kept", {31'd0, num_bytes_out_from_task_valid}, 32'd1);
  endtask

  initial begin
    int base_starts;
    bit ok;
    reset                = 1'b0;
    enabled_tasks        = '0;
    num_bytes_in_to_task = '0;
    start_tests          = 1'b0;
    task_done            = 1'b0;
    task_num_bytes_out   = '0;
    wr_ack               = 1'b0;
    tick();
    tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();

    $display("[TB] single task 1");
    case_one();

    $display("[TB] tasks 2, 4, 14");
    base_starts = starts_seen;
    apply_stimulus(32'h0000_4014, 32'd300);
    run_task(32'd2, 3, 32'd100, 0, 1'b0);
    check("multi_not_done_1", {31'd0, tasks_done}, 32'd0);
    run_task(32'd4, 1, 32'd5, 1, 1'b0);
    check("multi_not_done_2", {31'd0, tasks_done}, 32'd0);
    run_task(32'd14, 10, 32'd0, 0, 1'b0);
    check("multi_not_done_3", {31'd0, tasks_done}, 32'd0);
    wait_done("multi_tasks_done");
    watch_idle(3);
    check("multi_start_count", 32'(starts_seen - base_starts), 32'd3);

    $display("[TB] empty and out-of-range masks");
    foreach (sb[i]) bound_fail("scoreboard_leftover");
    base_starts = starts_seen;
    apply_stimulus(32'h0000_0000, 32'd1);
    check("empty_done_cycle1", {31'd0, tasks_done}, 32'd0);
    tick();
    check("empty_done_cycle2", {31'd0, tasks_done}, 32'd1);
    apply_stimulus(32'hFFFF_8001, 32'd1);
    check("ignored_bits_cycle1", {31'd0, tasks_done}, 32'd0);
    tick();
    check("ignored_bits_cycle2", {31'd0, tasks_done}, 32'd1);
    watch_idle(3);
    check("empty_no_start", 32'(starts_seen - base_starts), 32'd0);

    $display("[TB] restart during RUN and delayed ack");
    base_starts = starts_seen;
    apply_stimulus(32'h0000_0002, 32'd40);
    run_task(32'd1, 8, 32'd13, 5, 1'b1);
    wait_done("restart_tasks_done");
    watch_idle(4);
    check("restart_start_count", 32'(starts_seen - base_starts), 32'd1);
    check("restart_bytes_in_kept", task_num_bytes_in, 32'd40);

    $display("[TB] reset mid-RUN");
    apply_stimulus(32'h0000_0002, 32'd64);
    wait_task_start(ok);
    if (!ok) bound_fail("reset_case_start");
    watch_idle(5);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    check_reset_outputs();
    reset = 1'b1;
    base_starts = starts_seen;
    watch_idle(4);
    check("post_reset_no_start", 32'(starts_seen - base_starts), 32'd0);
    case_one();

`ifdef TASK_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    apply_stimulus(32'h0000_0002, 32'd16);
    wait_task_start(ok);
    if (!ok) bound_fail("timeout_case_start");
    begin
      int cycles;
      cycles = 0;
      while (!wr_req && cycles < 200) begin
        tick();
        cycles++;
      end
      if (!wr_req) bound_fail("timeout_wr_req");
      check("timeout_req_cycle", 32'(cycles), 32'd101);
    end
    check("timeout_flag", {31'd0, task_timeout}, 32'd1);
    sb.push_back('{addr: BASE, data: 32'hFFFF_FFFF, bytes: 32'd0});
    check_output(2);
    wait_done("timeout_tasks_done");
    check("timeout_flag_sticky", {31'd0, task_timeout}, 32'd1);
    apply_stimulus(32'h0000_0000, 32'd0);
    check("timeout_flag_cleared", {31'd0, task_timeout}, 32'd0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
